// File: rtl/l3_cnn_pkg.sv
// Shared constants and FSM state encoding for the layer-3 conv weight/bias loader.
package l3_cnn_pkg;

    localparam int L3_DW    = 16;
    localparam int L3_KTAPS = 9;
    localparam int L3_BANKS = 32;
    localparam int L3_DEPTH = 64;
    localparam int L3_AW    = $clog2(L3_DEPTH);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD_W  = 3'd1,
        ST_WRITE_W = 3'd2,
        ST_LOAD_B  = 3'd3,
        ST_WRITE_B = 3'd4,
        ST_CHK     = 3'd5,
        ST_DONE    = 3'd6
    } l3_state_e;

endpackage

// File: rtl/l3_conv_w_b_loader_if.sv
// Stream-in handshake plus weight/bias RAM write bus of the layer-3 loader.
interface l3_conv_w_b_loader_if #(
    parameter int DW    = l3_cnn_pkg::L3_DW,
    parameter int KTAPS = l3_cnn_pkg::L3_KTAPS,
    parameter int BANKS = l3_cnn_pkg::L3_BANKS,
    parameter int AW    = l3_cnn_pkg::L3_AW
) ();

    logic                  s_valid;
    logic                  s_ready;
    logic [DW-1:0]         s_data;
    logic [BANKS-1:0]      wr_en;
    logic [AW-1:0]         wr_addr;
    logic [DW*KTAPS-1:0]   wr_data;
    logic                  bias_we;
    logic [DW-1:0]         bias_data;

    modport master (
        input  s_valid, s_data,
        output s_ready, wr_en, wr_addr, wr_data, bias_we, bias_data
    );

    modport slave (
        output s_valid, s_data,
        input  s_ready, wr_en, wr_addr, wr_data, bias_we, bias_data
    );

endinterface

// File: rtl/l3_conv_w_b_loader_tap_packer.sv
// Nine-deep tap shift register: first tap ends up in the top word of the kernel.
module tap_packer #(
    parameter int DW    = 16,
    parameter int KTAPS = 9
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clear,
    input  logic                shift,
    input  logic [DW-1:0]       din,
    output logic                last,
    output logic                full,
    output logic [DW*KTAPS-1:0] pack
);

    localparam int CW = $clog2(KTAPS);

    logic [CW-1:0] cnt;

    assign last = (cnt == CW'(KTAPS - 1));

    // full marks a complete kernel and drops again on the next shift
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pack <= '0;
            cnt  <= '0;
            full <= 1'b0;
        end else if (clear) begin
            cnt  <= '0;
            full <= 1'b0;
        end else if (shift) begin
            pack <= {pack[DW*(KTAPS-1)-1:0], din};
            cnt  <= last ? '0 : cnt + CW'(1);
            full <= last;
        end
    end

endmodule

// File: rtl/l3_conv_w_b_loader.sv
// Layer-3 conv weight/bias loader: packs 9 taps per kernel into 32 banks x 64 addresses plus bias.
// Optional trailing checksum word when L3_LOADER_CHKSUM_EN is defined.
module l3_conv_w_b_loader
    import l3_cnn_pkg::*;
#(
    parameter int DW    = L3_DW,
    parameter int KTAPS = L3_KTAPS,
    parameter int BANKS = L3_BANKS,
    parameter int DEPTH = L3_DEPTH
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    l3_conv_w_b_loader_if.master   bus,
    output logic                   busy,
    output logic                   done,
    output logic                   chk_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int BW = $clog2(BANKS);

    l3_state_e              state, next;
    logic                   s_ready_q;
    logic [BANKS-1:0]       wr_en_q;
    logic                   bias_we_q;
    logic [DW-1:0]          bias_q;
    logic [BW-1:0]          bank;
    logic [AW-1:0]          addr;
    logic [DW*KTAPS-1:0]    pack;
    logic                   tap_last;
    logic                   kernel_full;
    logic                   accept;
    logic                   load_start;

    assign accept     = bus.s_valid && s_ready_q;
    assign load_start = (state == ST_IDLE) && start;

    tap_packer #(.DW(DW), .KTAPS(KTAPS)) u_packer (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (load_start),
        .shift (accept && (state == ST_LOAD_W)),
        .din   (bus.s_data),
        .last  (tap_last),
        .full  (kernel_full),
        .pack  (pack)
    );

    always_comb begin
        next = state;
        case (state)
            ST_IDLE:    if (start) next = ST_LOAD_W;
            ST_LOAD_W:  if (accept && tap_last) next = ST_WRITE_W;
            ST_WRITE_W: if (kernel_full) next = (bank == BW'(BANKS - 1)) ? ST_LOAD_B : ST_LOAD_W;
            ST_LOAD_B:  if (accept) next = ST_WRITE_B;
            ST_WRITE_B: begin
                if (addr != AW'(DEPTH - 1)) next = ST_LOAD_W;
`ifdef L3_LOADER_CHKSUM_EN
                else next = ST_CHK;
`else
                else next = ST_DONE;
`endif
            end
            ST_CHK:     if (accept) next = ST_DONE;
            ST_DONE:    next = ST_IDLE;
            default:    next = ST_IDLE;
        endcase
    end

    // All strobes are decoded from the next state so they appear registered
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            s_ready_q <= 1'b0;
            wr_en_q   <= '0;
            bias_we_q <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= next;
            s_ready_q <= (next == ST_LOAD_W) || (next == ST_LOAD_B) || (next == ST_CHK);
            wr_en_q   <= (next == ST_WRITE_W) ? (BANKS'(1) << bank) : '0;
            bias_we_q <= (next == ST_WRITE_B);
            busy      <= (next != ST_IDLE) && (next != ST_DONE);
            done      <= (next == ST_DONE);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bank   <= '0;
            addr   <= '0;
            bias_q <= '0;
        end else if (load_start) begin
            bank <= '0;
            addr <= '0;
        end else begin
            if (state == ST_WRITE_W && kernel_full)
                bank <= (bank == BW'(BANKS - 1)) ? '0 : bank + BW'(1);
            if (state == ST_WRITE_B && addr != AW'(DEPTH - 1))
                addr <= addr + AW'(1);
            if (state == ST_LOAD_B && accept)
                bias_q <= bus.s_data;
        end
    end

`ifdef L3_LOADER_CHKSUM_EN
    logic [DW-1:0] sum;
    logic          chk_q;

    // Sum covers every tap and bias word; the word taken in CHK is only compared
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum   <= '0;
            chk_q <= 1'b0;
        end else if (load_start) begin
            sum   <= '0;
            chk_q <= 1'b0;
        end else if (accept) begin
            if (state == ST_CHK)
                chk_q <= (bus.s_data != sum);
            else
                sum <= sum + bus.s_data;
        end
    end

    assign chk_err = chk_q;
`else
    assign chk_err = 1'b0;
`endif

    assign bus.s_ready   = s_ready_q;
    assign bus.wr_en     = wr_en_q;
    assign bus.wr_addr   = addr;
    assign bus.wr_data   = pack;
    assign bus.bias_we   = bias_we_q;
    assign bus.bias_data = bias_q;

endmodule

// File: doc/l3_conv_w_b_loader.md
# l3_conv_w_b_loader

Streaming writer for the layer-3 convolution weight and bias memories. It accepts a word stream and packs every nine 16-bit taps into one 144-bit 3x3 kernel. It writes each kernel into one of 32 weight banks, then writes one bias word per address, across all 64 addresses. It sits between the host/UART download path and the layer-3 weight/bias RAMs, whose read side feeds the layer-3 conv engine.

## Interface
Parameters:
- `DW`, 16, tap/bias word width
- `KTAPS`, 9, taps per kernel (kernel width = `DW*KTAPS` = 144)
- `BANKS`, 32, number of weight banks
- `DEPTH`, 64, addresses per bank (`AW` = clog2(`DEPTH`) = 6)

Ports:
- `clk` in 1: single clock, rising edge
- `rst_n` in 1: asynchronous, active-low reset
- `start` in 1: one-cycle pulse that begins a full load
- `s_valid` in 1: stream word valid
- `s_ready` out 1: loader accepts a word this cycle
- `s_data` in `DW`: stream word, two's complement
- `wr_en` out `BANKS`: one-hot weight-bank write strobe
- `wr_addr` out `AW`: shared write address for weights and bias
- `wr_data` out `DW*KTAPS`: packed kernel
- `bias_we` out 1: bias RAM write strobe
- `bias_data` out `DW`: bias word
- `busy` out 1: high from the cycle after an accepted `start` until `done`
- `done` out 1: one-cycle pulse when the load completes
- `chk_err` out 1: checksum mismatch, sticky until the next `start`

## Operation
- Stream order, per address 0..63: bank 0..31, each bank's 9 taps; then 1 bias word.
- Total words: 64 × 289 = 18496.
- FSM states: IDLE, LOAD_W, WRITE_W, LOAD_B, WRITE_B, (CHK), DONE.
- IDLE:
  - `start` → LOAD_W.
  - Clears tap, bank and address counters, and clears `chk_err`.
- LOAD_W:
  - `s_ready`=1. Each handshake (`s_valid && s_ready`) shifts the word into the pack register.
  - The first tap lands in `wr_data[143:128]`; the ninth tap in `[15:0]`.
  - On the 9th accepted tap → WRITE_W.
- WRITE_W:
  - `s_ready`=0. `wr_en[bank]`=1 for exactly one cycle; `wr_addr`=address.
  - If bank<31: bank++ → LOAD_W. Otherwise bank=0 → LOAD_B.
- LOAD_B:
  - `s_ready`=1. One accepted word is latched into `bias_data` → WRITE_B.
- WRITE_B:
  - `bias_we`=1 for one cycle.
  - If address<63: address++ → LOAD_W. Otherwise → CHK (macro) or DONE.
- DONE: `done`=1 for one cycle → IDLE.
- `start` while `busy` is ignored. `s_valid` in IDLE/DONE/WRITE_* is not consumed.
- Only `s_data` stalls are tolerated: the FSM holds in LOAD_* while `s_valid`=0, with no timeout.

## Timing
- Reset values:
  - `s_ready`, `wr_en`, `bias_we`, `busy`, `done`, `chk_err` = 0.
  - `wr_addr`, `wr_data`, `bias_data` = 0.
  - State = IDLE.
- All outputs are registered.
- The write strobe asserts in the cycle after the 9th-tap (or bias) handshake.
- Per-kernel throughput: 10 cycles at full stream rate (9 accept + 1 write).
- Per-address throughput: 32×10 + 2 = 322 cycles. Full load: 20608 cycles plus 1 for `done` (plus 1 CHK with the macro).
- `wr_data` and `wr_addr` stay stable during the `wr_en` cycle and hold until the next shift.
- `rst_n` low mid-load aborts immediately: outputs go to their reset values and no partial write occurs. The next `start` restarts from address 0.
- Counters never wrap mid-load. Address 63 → terminal.

## Configuration
- `L3_LOADER_CHKSUM_EN` defined:
  - A 16-bit modular sum of all 18496 accepted data words is kept.
  - After the last WRITE_B, the FSM enters CHK with `s_ready`=1 and accepts one extra word.
  - If that word ≠ the sum, `chk_err`=1.
  - Then DONE.
- `L3_LOADER_CHKSUM_EN` undefined: no CHK state, no extra word, `chk_err` tied 0.

## Structure
- Shared package `l3_cnn_pkg`:
  - Constants `L3_DW`, `L3_KTAPS`, `L3_BANKS`, `L3_DEPTH`, `L3_AW`.
  - The state enum typedef.
- One natural sub-module, `tap_packer`: a 9-deep `DW` shift register with a tap counter and a `full` flag.

## Test plan
- Reset, then idle with `s_valid`=1: all outputs 0 and no `wr_en` for 100 cycles.
- Address 0, bank 0 taps 0x0001..0x0009: `wr_en`=0x00000001, `wr_addr`=0, `wr_data`=0x0001_0002_…_0009.
- Full load at full rate, bias word = address: `bias_we` pulses 64 times with `bias_data`=0..63, `wr_en` pulses 2048 times, and `done` arrives at cycle 20609 after `start`.
- Random `s_valid` gaps (50% duty) plus a second `start` mid-load: memory contents are identical to the gap-free run, and the extra `start` is ignored.
- `rst_n` pulse low after 1000 words, then a fresh `start`: no writes during reset, and the load completes correctly from address 0.
- With `L3_LOADER_CHKSUM_EN`, correct trailing sum → `chk_err`=0. Sum+1 → `chk_err`=1, held until the next `start`.
